// File: rtl/condition_flags_unit.sv
// Execute-stage NZCV flag register and branch resolver (B.cond, CBZ, CBNZ).
// Latency: one cycle from inputs to flags and branch_taken (both registered).
// Backpressure: stall freezes all state; flush squashes the instruction and clears branch_taken.
//
// Parameters:
//   WIDTH         operand/result width (defaults to `WORD = 64)
// Optional feature macro:
//   FLAG_BYPASS_EN  when defined, a B.cond in the same cycle as a flag-setting
//                   instruction evaluates against the freshly computed flags.
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   a_in, b_in          ALU operands (same values the ALU sees)
//   alu_control         ALU operation code (`ALU_ADD/SUB/AND/ORR/PASS)
//   alu_result, zero    ALU result and zero indication
//   set_flags           instruction writes NZCV
//   cond_valid, cond    B.cond request and its condition code
//   cbz, cbnz           compare-and-branch requests (use zero)
//   stall, flush        pipeline hold / squash
//   flags               registered {N,Z,C,V}
//   branch_taken        registered branch decision for EX/MEM

`ifndef WORD
`define WORD 64
`endif
`ifndef ALU_AND
`define ALU_AND  4'b0000
`endif
`ifndef ALU_ORR
`define ALU_ORR  4'b0001
`endif
`ifndef ALU_ADD
`define ALU_ADD  4'b0010
`endif
`ifndef ALU_SUB
`define ALU_SUB  4'b0110
`endif
`ifndef ALU_PASS
`define ALU_PASS 4'b0111
`endif

module condition_flags_unit #(
  parameter int WIDTH = `WORD
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             zero,
  input  logic             set_flags,
  input  logic             cond_valid,
  input  logic [3:0]       cond,
  input  logic             cbz,
  input  logic             cbnz,
  input  logic             stall,
  input  logic             flush,
  output logic [3:0]       flags,
  output logic             branch_taken
);

  logic [3:0] flags_q, flags_d;
  logic       branch_taken_q, branch_taken_d;
  logic [3:0] next_flags;
  logic [3:0] eval_flags;
  logic       taken;

  logic res_msb, a_msb, b_msb;
  logic flag_n, flag_z, flag_c, flag_v;

  assign res_msb = alu_result[WIDTH-1];
  assign a_msb   = a_in[WIDTH-1];
  assign b_msb   = b_in[WIDTH-1];

  // Condition-code evaluation against a {N,Z,C,V} vector.
  function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    logic r;
    n  = f[3];
    z  = f[2];
    cy = f[1];
    v  = f[0];
    r  = 1'b0;
    unique case (c)
      4'b0000: r = z;
      4'b0001: r = !z;
      4'b0010: r = cy;
      4'b0011: r = !cy;
      4'b0100: r = n;
      4'b0101: r = !n;
      4'b0110: r = v;
      4'b0111: r = !v;
      4'b1000: r = cy & !z;
      4'b1001: r = !(cy & !z);
      4'b1010: r = (n == v);
      4'b1011: r = (n != v);
      4'b1100: r = !z & (n == v);
      4'b1101: r = !(!z & (n == v));
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  // Next flags from the current ALU operation.
  always_comb begin
    flag_n = res_msb;
    flag_z = (alu_result == '0);
    flag_c = 1'b0;
    flag_v = 1'b0;
    case (alu_control)
      `ALU_ADD: begin
        // Carry out of a+b occurs exactly when a exceeds the complement of b.
        flag_c = (a_in > ~b_in);
        flag_v = (a_msb == b_msb) && (res_msb != a_msb);
      end
      `ALU_SUB: begin
        // ARM carry on subtract is "no borrow".
        flag_c = (a_in >= b_in);
        flag_v = (a_msb != b_msb) && (res_msb != a_msb);
      end
      default: begin
        flag_c = 1'b0;
        flag_v = 1'b0;
      end
    endcase
    next_flags = {flag_n, flag_z, flag_c, flag_v};
  end

`ifdef FLAG_BYPASS_EN
  assign eval_flags = set_flags ? next_flags : flags_q;
`else
  // The pipeline spaces a dependent B.cond at least one cycle after set_flags.
  assign eval_flags = flags_q;
`endif

  // Branch resolution; CBZ wins over CBNZ, which wins over B.cond.
  always_comb begin
    taken = 1'b0;
    if (cbz)
      taken = zero;
    else if (cbnz)
      taken = !zero;
    else if (cond_valid)
      taken = cond_eval(cond, eval_flags);
  end

  always_comb begin
    flags_d        = flags_q;
    branch_taken_d = branch_taken_q;
    if (set_flags && !stall && !flush)
      flags_d = next_flags;
    if (flush)
      branch_taken_d = 1'b0;
    else if (!stall)
      branch_taken_d = taken;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q        <= 4'b0000;
      branch_taken_q <= 1'b0;
    end else begin
      flags_q        <= flags_d;
      branch_taken_q <= branch_taken_d;
    end
  end

  assign flags        = flags_q;
  assign branch_taken = branch_taken_q;

endmodule
